nx1_pcm_i2s: RTL
================

// Module: nx1_pcm_i2s
// PURPOSE
//  Downstream audio stage for the slot FM board: consumes pcm_lch/pcm_rch/pcm_load,
//  buffers stereo samples in a small FIFO and serializes them as Philips I2S to the
//  board audio DAC. The source load rate and the I2S frame rate are independent;
//  the FIFO absorbs jitter, and defined repeat/drop rules resolve rate mismatch.
// PARAMETERS
//  DIV_BCLK   8  sysclk cycles per BCLK half-period, >=2 (32MHz/16 = 2MHz BCLK, fs=31.25kHz)
//  FIFO_AW    2  FIFO address width; depth = 2**FIFO_AW stereo entries
// PORTS
//  slot_sysclk  in   1   system clock (32MHz); sole clock
//  slot_reset   in   1   synchronous reset, active-high
//  pcm_lch      in   16  left sample, two's complement
//  pcm_rch      in   16  right sample, two's complement
//  pcm_load     in   1   1-cycle strobe: push {pcm_lch,pcm_rch}
//  pcm_att      in   4   attenuation shift (used only with NX1_PCM_ATT_EN)
//  stat_clr     in   1   1-cycle strobe: clear stat_unf/stat_ovf
//  i2s_bclk     out  1   bit clock
//  i2s_lrck     out  1   word select, 0=left 1=right
//  i2s_sdata    out  1   serial data, MSB first
//  fifo_level   out  FIFO_AW+1  entries currently held
//  stat_unf     out  1   sticky: frame start found FIFO empty
//  stat_ovf     out  1   sticky: push dropped because FIFO full
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; holding reg {L,R}=0; divider/bit counters 0.
//  Reset mid-frame aborts the frame; a new frame restarts from bit 0, left slot.
//  Divider: counts 0..DIV_BCLK-1; on terminal count i2s_bclk toggles.
//  Frame: 64 BCLK periods, bit index b=0..63 advanced on each BCLK falling edge.
//   lrck=0 for b=0..31, 1 for b=32..63 (changes on falling edge).
//   sdata one BCLK late per I2S: slot bit k (k=0..31 within half) drives
//   sample[15-(k-1)] for k=1..16, 0 for k=0 and k=17..31.
//  Frame start (b wraps 63->0, falling edge): if FIFO non-empty pop into holding reg;
//   else keep holding reg (repeat last sample) and set stat_unf. Both channels of a
//   frame always come from the same holding reg value.
//  FIFO push on pcm_load: if not full, write; if full, drop new sample, set stat_ovf.
//  Push and pop in same cycle: pop first, push always accepted, level unchanged.
//  fifo_level registered; updates the cycle after push/pop.
//  stat_clr and a new set event in same cycle: set wins.
//  pcm_load latency: sample pushed into empty FIFO appears on sdata at the next
//   frame start + 1 BCLK; sysclk latency = up to 64*2*DIV_BCLK + 2*DIV_BCLK.
//  Pointers wrap modulo 2**FIFO_AW; level range 0..2**FIFO_AW.
// CONFIGURATION
//  NX1_PCM_ATT_EN defined: on pop, each channel = sample >>> pcm_att (arithmetic,
//   sign kept; pcm_att sampled at pop). pcm_att=15 yields 0 or -1.
//  NX1_PCM_ATT_EN undefined: pcm_att ignored, samples passed unmodified.
// TESTING
//  1 Reset, no loads, run 2 frames -> bclk period 16 clk, lrck period 1024 clk,
//    sdata constant 0, stat_unf=1 after first frame start.
//  2 Load L=16'h8001 R=16'h7FFE once -> next frame left bits 1000_0000_0000_0001
//    on b=1..16, right 0111_1111_1111_1110 on b=33..48, zeros elsewhere.
//  3 Load 5 samples back-to-back (depth 4) -> fifo_level=4, stat_ovf=1, 5th dropped;
//    frames output samples 1..4 in order, then sample 4 repeated, stat_unf set.
//  4 With level=4, pcm_load coincident with frame-start pop -> level stays 4, no ovf.
//  5 stat_clr while underrun frame start in same cycle -> stat_unf stays 1.
//  6 NX1_PCM_ATT_EN, pcm_att=4, L=16'hF000 R=16'h0100 -> L=16'hFF00 R=16'h0010 out.

Source files
------------

// File: rtl/nx1_pcm_i2s_if.sv
// Signal bundle between the PCM sample source and the I2S serializer.
// The master is the source/observer side. The slave is the serializer.
interface nx1_pcm_i2s_if #(
    parameter int FIFO_AW = 2
);
    logic [15:0]      pcm_lch;
    logic [15:0]      pcm_rch;
    logic             pcm_load;
    logic [3:0]       pcm_att;
    logic             stat_clr;
    logic             i2s_bclk;
    logic             i2s_lrck;
    logic             i2s_sdata;
    logic [FIFO_AW:0] fifo_level;
    logic             stat_unf;
    logic             stat_ovf;

    modport master (
        output pcm_lch, pcm_rch, pcm_load, pcm_att, stat_clr,
        input  i2s_bclk, i2s_lrck, i2s_sdata, fifo_level, stat_unf, stat_ovf
    );

    modport slave (
        input  pcm_lch, pcm_rch, pcm_load, pcm_att, stat_clr,
        output i2s_bclk, i2s_lrck, i2s_sdata, fifo_level, stat_unf, stat_ovf
    );
endinterface

// File: rtl/nx1_pcm_i2s.sv
// Stereo PCM FIFO feeding a Philips I2S serializer (64 BCLK per frame, 16-bit slots).
// Define NX1_PCM_ATT_EN to shift popped samples right by pcm_att (arithmetic).
module nx1_pcm_i2s #(
    parameter int DIV_BCLK = 8,
    parameter int FIFO_AW  = 2
) (
    input logic          slot_sysclk,
    input logic          slot_reset,
    nx1_pcm_i2s_if.slave bus
);
    localparam int DEPTH  = 2 ** FIFO_AW;
    localparam int DIV_CW = $clog2(DIV_BCLK);

    logic [DIV_CW-1:0]  div_q, div_d;
    logic               bclk_q, bclk_d;
    logic [5:0]         bit_q, bit_d;
    logic               sdata_q, sdata_d;
    logic [31:0]        mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   level_q, level_d;
    logic [15:0]        hold_l_q, hold_l_d;
    logic [15:0]        hold_r_q, hold_r_d;
    logic               unf_q, unf_d;
    logic               ovf_q, ovf_d;

    logic               tick, fall, frame_start, empty, full, pop, push;
    logic [31:0]        pop_word;
    logic [4:0]         slot_k;
    logic [3:0]         slot_idx;
    logic [15:0]        slot_word;

    assign tick        = (div_q == DIV_CW'(DIV_BCLK - 1));
    assign fall        = tick && bclk_q;
    assign frame_start = fall && (bit_q == 6'd63);
    assign empty       = (level_q == '0);
    assign full        = (level_q == (FIFO_AW + 1)'(DEPTH));
    // Pop is evaluated first, so a load on a full FIFO still lands when a frame starts.
    assign pop         = frame_start && !empty;
    assign push        = bus.pcm_load && (!full || pop);
    assign pop_word    = mem_q[rd_ptr_q];

`ifndef NX1_PCM_ATT_EN
    logic unused_att;
    assign unused_att = ^bus.pcm_att;
`endif

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        div_d     = tick ? '0 : div_q + 1'b1;
        bclk_d    = tick ? ~bclk_q : bclk_q;
        bit_d     = fall ? bit_q + 6'd1 : bit_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        hold_l_d  = hold_l_q;
        hold_r_d  = hold_r_q;
        sdata_d   = sdata_q;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
`ifdef NX1_PCM_ATT_EN
            hold_l_d = $signed(pop_word[31:16]) >>> bus.pcm_att;
            hold_r_d = $signed(pop_word[15:0])  >>> bus.pcm_att;
`else
            hold_l_d = pop_word[31:16];
            hold_r_d = pop_word[15:0];
`endif
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end

        // Data trails lrck by one BCLK: slot bit k carries sample bit 16-k for k=1..16.
        slot_k    = bit_d[4:0];
        slot_word = bit_d[5] ? hold_r_d : hold_l_d;
        slot_idx  = 4'(5'd16 - slot_k);
        if (fall) begin
            sdata_d = (slot_k != 5'd0) && (slot_k <= 5'd16) && slot_word[slot_idx];
        end

        unf_d = (unf_q && !bus.stat_clr) || (frame_start && empty);
        ovf_d = (ovf_q && !bus.stat_clr) || (bus.pcm_load && full && !pop);
    end

    always_ff @(posedge slot_sysclk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (slot_reset) begin
            div_q    <= '0;
            bclk_q   <= 1'b0;
            bit_q    <= '0;
            sdata_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            hold_l_q <= '0;
            hold_r_q <= '0;
            unf_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            div_q    <= div_d;
            bclk_q   <= bclk_d;
            bit_q    <= bit_d;
            sdata_q  <= sdata_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            hold_l_q <= hold_l_d;
            hold_r_q <= hold_r_d;
            unf_q    <= unf_d;
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: FIFO storage is not reset; the pointers and level define which entries are valid.
    always_ff @(posedge slot_sysclk) begin
        if (push && !slot_reset) begin
            mem_q[wr_ptr_q] <= {bus.pcm_lch, bus.pcm_rch};
        end
    end

    assign bus.i2s_bclk   = bclk_q;
    assign bus.i2s_lrck   = bit_q[5];
    assign bus.i2s_sdata  = sdata_q;
    assign bus.fifo_level = level_q;
    assign bus.stat_unf   = unf_q;
    assign bus.stat_ovf   = ovf_q;
endmodule
